// File: rtl/chacha_pkg.sv
// chacha_pkg
//   Shared definitions for the ChaCha keystream block: sigma constant words,
//   parameter legality checks, FSM state encoding and beat-count helper.
package chacha_pkg;

   // "expand 32-byte k" as four little-endian words
   localparam logic [31:0] SIGMA0 = 32'h6170_7865;
   localparam logic [31:0] SIGMA1 = 32'h3320_646e;
   localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
   localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2,
      ST_READY = 2'd3
   } state_e;

   function automatic bit rounds_legal(input int unsigned rounds);
      return (rounds == 8) || (rounds == 12) || (rounds == 20);
   endfunction

   function automatic bit bus_legal(input int unsigned bus_w);
      return (bus_w == 8) || (bus_w == 16) || (bus_w == 32);
   endfunction

   function automatic int unsigned beats_per_field(input int unsigned field_bits,
                                                   input int unsigned bus_w);
      return field_bits / bus_w;
   endfunction

endpackage

// File: rtl/chacha_qr.sv
// chacha_qr
//   Combinational ChaCha quarter-round.
//   Ports: a_i..d_i - four 32-bit input words
//          a_o..d_o - four 32-bit output words
module chacha_qr (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);

   function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
      return (v << n) | (v >> (32 - n));
   endfunction

   logic [31:0] a1, b1, c1, d1;
   logic [31:0] a2, b2, c2, d2;

   always_comb begin
      a1  = a_i + b_i;
      d1  = rotl(d_i ^ a1, 16);
      c1  = c_i + d1;
      b1  = rotl(b_i ^ c1, 12);
      a2  = a1 + b1;
      d2  = rotl(d1 ^ a2, 8);
      c2  = c1 + d2;
      b2  = rotl(b1 ^ c2, 7);
      a_o = a2;
      b_o = b2;
      c_o = c2;
      d_o = d2;
   end

endmodule

// File: rtl/chacha_stream.sv
// chacha_stream
//   Beat-serial ChaCha keystream generator (RFC 8439 state layout). Key,
//   nonce and counter are loaded little-endian over data_in; the final
//   counter beat starts a block. One quarter-round is evaluated per cycle.
//   Ports: clk, rst_n (async, active-low)
//          data_in            - write beat
//          wr_key/wr_nnc/wr_ctr - field write strobes (priority in that order)
//          rd_blk             - consume one keystream beat (READY only)
//          auto_inc           - on final-beat read, bump counter and recompute
//          data_out           - keystream beat at read pointer, 0 outside READY
//          blk_ready, busy    - block valid / computation in progress
module chacha_stream
   import chacha_pkg::*;
#(
   parameter int unsigned BUS_W       = 8,
   parameter int unsigned ROUNDS      = 20,
   parameter bit          AUTO_INC_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BUS_W-1:0] data_in,
   input  logic             wr_key,
   input  logic             wr_nnc,
   input  logic             wr_ctr,
   input  logic             rd_blk,
   input  logic             auto_inc,
   output logic [BUS_W-1:0] data_out,
   output logic             blk_ready,
   output logic             busy
);

   if (!rounds_legal(ROUNDS) || !bus_legal(BUS_W)) begin : g_param_check
      $error("chacha_stream: illegal BUS_W or ROUNDS");
   end

   localparam int unsigned KEY_BEATS = beats_per_field(256, BUS_W);
   localparam int unsigned NNC_BEATS = beats_per_field(96, BUS_W);
   localparam int unsigned CTR_BEATS = beats_per_field(32, BUS_W);
   localparam int unsigned BLK_BEATS = beats_per_field(512, BUS_W);
   localparam int unsigned KP_W = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;
   localparam int unsigned NP_W = (NNC_BEATS > 1) ? $clog2(NNC_BEATS) : 1;
   localparam int unsigned CP_W = (CTR_BEATS > 1) ? $clog2(CTR_BEATS) : 1;
   localparam int unsigned RP_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
   localparam int unsigned QR_CYCLES = ROUNDS * 4;
   localparam int unsigned RC_W = $clog2(QR_CYCLES);

   localparam logic [KP_W-1:0] KP_LAST  = KP_W'(KEY_BEATS - 1);
   localparam logic [NP_W-1:0] NP_LAST  = NP_W'(NNC_BEATS - 1);
   localparam logic [CP_W-1:0] CP_LAST  = CP_W'(CTR_BEATS - 1);
   localparam logic [RP_W-1:0] RP_LAST  = RP_W'(BLK_BEATS - 1);
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(QR_CYCLES - 1);

   state_e            state_q, state_d;
   logic [255:0]      key_q, key_d;
   logic [95:0]       nnc_q, nnc_d;
   logic [31:0]       ctr_q, ctr_d;
   logic [KP_W-1:0]   kptr_q, kptr_d;
   logic [NP_W-1:0]   nptr_q, nptr_d;
   logic [CP_W-1:0]   cptr_q, cptr_d;
   logic [RP_W-1:0]   rptr_q, rptr_d;
   logic [RC_W-1:0]   rc_q;
   logic              load_q;
   logic [15:0][31:0] in_q, w_q, init_st;
   logic [511:0]      blk_flat;

   logic              wr_acc, start, rd_last;
   logic              diag;
   logic [1:0]        q_sel, sel_b, sel_c, sel_d;
   logic [3:0]        ia, ib, ic, id;
   logic [31:0]       qa_o, qb_o, qc_o, qd_o;

   // Strobe decode, field writes and read pointer
   always_comb begin
      key_d   = key_q;
      nnc_d   = nnc_q;
      ctr_d   = ctr_q;
      kptr_d  = kptr_q;
      nptr_d  = nptr_q;
      cptr_d  = cptr_q;
      rptr_d  = rptr_q;
      wr_acc  = wr_key | wr_nnc | wr_ctr;
      start   = 1'b0;
      rd_last = 1'b0;
      if (wr_key) begin
         key_d[kptr_q*BUS_W +: BUS_W] = data_in;
         kptr_d = (kptr_q == KP_LAST) ? '0 : kptr_q + KP_W'(1);
      end else if (wr_nnc) begin
         nnc_d[nptr_q*BUS_W +: BUS_W] = data_in;
         nptr_d = (nptr_q == NP_LAST) ? '0 : nptr_q + NP_W'(1);
      end else if (wr_ctr) begin
         ctr_d[cptr_q*BUS_W +: BUS_W] = data_in;
         if (cptr_q == CP_LAST) begin
            cptr_d = '0;
            start  = 1'b1;
         end else begin
            cptr_d = cptr_q + CP_W'(1);
         end
      end else if (rd_blk && (state_q == ST_READY)) begin
         if (rptr_q == RP_LAST) begin
            rptr_d  = '0;
            rd_last = 1'b1;
            if (AUTO_INC_EN && auto_inc) begin
               ctr_d = ctr_q + 32'd1;
               start = 1'b1;
            end
         end else begin
            rptr_d = rptr_q + RP_W'(1);
         end
      end
      if (wr_acc) begin
         rptr_d = '0;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      if (wr_acc) begin
         state_d = start ? ST_ROUND : ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_IDLE;
            ST_ROUND: if (!load_q && (rc_q == RC_LAST)) state_d = ST_FINAL;
            ST_FINAL: state_d = ST_READY;
            ST_READY: if (rd_last) state_d = start ? ST_ROUND : ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Input state is built from the next-cycle field values so a counter
   // bumped by auto-increment is used in the block it starts.
   assign init_st  = {nnc_d, ctr_d, key_d, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
   assign blk_flat = w_q;

   // rc_q[2] selects column vs diagonal pass, rc_q[1:0] the quarter-round
   always_comb begin
      diag  = rc_q[2];
      q_sel = rc_q[1:0];
      sel_b = q_sel + {1'b0, diag};
      sel_c = q_sel + {diag, 1'b0};
      sel_d = q_sel + {diag, diag};
      ia    = {2'b00, q_sel};
      ib    = {2'b01, sel_b};
      ic    = {2'b10, sel_c};
      id    = {2'b11, sel_d};
   end

   chacha_qr u_qr (
      .a_i (w_q[ia]),
      .b_i (w_q[ib]),
      .c_i (w_q[ic]),
      .d_i (w_q[id]),
      .a_o (qa_o),
      .b_o (qb_o),
      .c_o (qc_o),
      .d_o (qd_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Start snapshots the input state; the first ROUND cycle copies it into
   // the working state, then ROUNDS*4 quarter-rounds follow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q  <= '0;
         nnc_q  <= '0;
         ctr_q  <= '0;
         kptr_q <= '0;
         nptr_q <= '0;
         cptr_q <= '0;
         rptr_q <= '0;
         rc_q   <= '0;
         load_q <= 1'b0;
         in_q   <= '0;
         w_q    <= '0;
      end else begin
         key_q  <= key_d;
         nnc_q  <= nnc_d;
         ctr_q  <= ctr_d;
         kptr_q <= kptr_d;
         nptr_q <= nptr_d;
         cptr_q <= cptr_d;
         rptr_q <= rptr_d;
         if (start) begin
            in_q   <= init_st;
            load_q <= 1'b1;
            rc_q   <= '0;
         end else if (wr_acc) begin
            load_q <= 1'b0;
            rc_q   <= '0;
         end else if (state_q == ST_ROUND) begin
            if (load_q) begin
               w_q    <= in_q;
               load_q <= 1'b0;
            end else begin
               w_q[ia] <= qa_o;
               w_q[ib] <= qb_o;
               w_q[ic] <= qc_o;
               w_q[id] <= qd_o;
               rc_q    <= (rc_q == RC_LAST) ? '0 : rc_q + RC_W'(1);
            end
         end else if (state_q == ST_FINAL) begin
            for (int unsigned i = 0; i < 16; i++) begin
               w_q[i] <= w_q[i] + in_q[i];
            end
         end
      end
   end

   assign blk_ready = (state_q == ST_READY);
   assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);

   always_comb begin
      data_out = '0;
      if (state_q == ST_READY) begin
         data_out = blk_flat[rptr_q*BUS_W +: BUS_W];
      end
   end

endmodule

// File: tb/tb_chacha_stream.sv
// tb_chacha_stream
//   Scoreboard bench for chacha_stream: an 8-bit and a 32-bit instance.
//   Expected keystream beats are queued when reads are issued and checked
//   by monitors at the falling edge.
module tb_chacha_stream;

   localparam int unsigned ROUNDS = 20;
   localparam int unsigned LAT    = ROUNDS * 4 + 2;

   // RFC 8439 section 2.3.2 block (key 00..1f, counter 1)
   localparam logic [31:0] RFC_W [16] = '{
      32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic        wr_key, wr_nnc, wr_ctr, rd_blk, auto_inc;
   logic [7:0]  dout;
   logic        blk_ready, busy;
   logic [31:0] din32;
   logic        wk32, wn32, wc32, rd32;
   logic [31:0] dout32;
   logic        rdy32, busy32;

   int checks = 0;
   int errors = 0;

   logic [7:0]   exp8_q  [$];
   logic [31:0]  exp32_q [$];
   logic [255:0] key_v;
   logic [95:0]  nnc_v;
   logic [511:0] rfc_blk;

   always #5 clk = ~clk;

   chacha_stream #(.BUS_W(8), .ROUNDS(ROUNDS), .AUTO_INC_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(din), .wr_key(wr_key), .wr_nnc(wr_nnc),
      .wr_ctr(wr_ctr), .rd_blk(rd_blk), .auto_inc(auto_inc), .data_out(dout),
      .blk_ready(blk_ready), .busy(busy));

   chacha_stream #(.BUS_W(32), .ROUNDS(ROUNDS), .AUTO_INC_EN(1'b1)) dut32 (
      .clk(clk), .rst_n(rst_n), .data_in(din32), .wr_key(wk32), .wr_nnc(wn32),
      .wr_ctr(wc32), .rd_blk(rd32), .auto_inc(1'b0), .data_out(dout32),
      .blk_ready(rdy32), .busy(busy32));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   // Independent reference block function
   function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
      logic [31:0] s [16];
      logic [31:0] x [16];
      logic [31:0] a, b, cc, d;
      logic [511:0] r;
      int t [8][4];
      t = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
            '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
      s[12] = c;
      for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
      for (int i = 0; i < 16; i++) x[i] = s[i];
      for (int dr = 0; dr < ROUNDS / 2; dr++) begin
         for (int j = 0; j < 8; j++) begin
            a = x[t[j][0]]; b = x[t[j][1]]; cc = x[t[j][2]]; d = x[t[j][3]];
            a = a + b;  d = rotl(d ^ a, 16);
            cc = cc + d; b = rotl(b ^ cc, 12);
            a = a + b;  d = rotl(d ^ a, 8);
            cc = cc + d; b = rotl(b ^ cc, 7);
            x[t[j][0]] = a; x[t[j][1]] = b; x[t[j][2]] = cc; x[t[j][3]] = d;
         end
      end
      for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
      return r;
   endfunction

   // Drive the 8-bit instance for the next rising edge
   task automatic step8(input logic wk, input logic wn, input logic wc, input logic rd,
                        input logic ai, input logic [7:0] d);
      @(posedge clk);
      #1;
      wr_key = wk; wr_nnc = wn; wr_ctr = wc; rd_blk = rd; auto_inc = ai; din = d;
   endtask

   task automatic idle8();
      step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic step32(input logic wk, input logic wn, input logic wc, input logic rd,
                         input logic [31:0] d);
      @(posedge clk);
      #1;
      wk32 = wk; wn32 = wn; wc32 = wc; rd32 = rd; din32 = d;
   endtask

   task automatic write_key8(input logic [255:0] k);
      for (int i = 0; i < 32; i++) step8(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, k[8*i +: 8]);
   endtask

   task automatic write_nnc8(input logic [95:0] n);
      for (int i = 0; i < 12; i++) step8(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, n[8*i +: 8]);
   endtask

   task automatic write_ctr8(input logic [31:0] c);
      for (int i = 0; i < 4; i++) step8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c[8*i +: 8]);
   endtask

   // Count edges from the busy-rise sample until blk_ready, bounded
   task automatic wait_ready8(input string name);
      int n;
      n = 0;
      while (blk_ready !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, n, LAT);
      chk({name, "_busy_low"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic read8(input logic [511:0] blk, input int nbeats, input logic ai);
      for (int i = 0; i < nbeats; i++) begin
         exp8_q.push_back(blk[8*i +: 8]);
         step8(1'b0, 1'b0, 1'b0, 1'b1, ai, 8'h00);
      end
   endtask

   // Monitors: a beat is presented whenever a read is accepted
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rd_blk && blk_ready && !(wr_key || wr_nnc || wr_ctr)) begin
            if (exp8_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd8_unexpected got=%h expected=none", dout);
            end else begin
               e = exp8_q.pop_front();
               chk("rd8_beat", {24'd0, dout}, {24'd0, e});
            end
         end
      end
   end

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && rd32 && rdy32 && !(wk32 || wn32 || wc32)) begin
            if (exp32_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd32_unexpected got=%h expected=none", dout32);
            end else begin
               e = exp32_q.pop_front();
               chk("rd32_beat", dout32, e);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [511:0] blk_ff, blk_00;
      for (int i = 0; i < 32; i++) key_v[8*i +: 8] = 8'(i);
      nnc_v = {32'h0000_0000, 32'h4a00_0000, 32'h0900_0000};
      for (int i = 0; i < 16; i++) rfc_blk[32*i +: 32] = RFC_W[i];
      blk_ff = chacha_ref(key_v, 32'hFFFF_FFFF, nnc_v);
      blk_00 = chacha_ref(key_v, 32'h0000_0000, nnc_v);

      rst_n = 1'b0;
      wr_key = 0; wr_nnc = 0; wr_ctr = 0; rd_blk = 0; auto_inc = 0; din = '0;
      wk32 = 0; wn32 = 0; wc32 = 0; rd32 = 0; din32 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dout8", {24'd0, dout}, 32'd0);
      chk("rst_ready8", {31'd0, blk_ready}, 32'd0);
      chk("rst_busy8", {31'd0, busy}, 32'd0);
      chk("rst_dout32", dout32, 32'd0);
      chk("rst_ready32", {31'd0, rdy32}, 32'd0);
      chk("rst_busy32", {31'd0, busy32}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 32-bit bus: RFC vector, 16 reads then not ready
      for (int i = 0; i < 8; i++) step32(1'b1, 1'b0, 1'b0, 1'b0, key_v[32*i +: 32]);
      for (int i = 0; i < 3; i++) step32(1'b0, 1'b1, 1'b0, 1'b0, nnc_v[32*i +: 32]);
      step32(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001);
      step32(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("busy32_start", {31'd0, busy32}, 32'd1);
      n = 0;
      while (rdy32 !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("lat32", n, LAT);
      for (int i = 0; i < 16; i++) begin
         exp32_q.push_back(rfc_blk[32*i +: 32]);
         step32(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      end
      step32(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("ready32_after_block", {31'd0, rdy32}, 32'd0);
      chk("busy32_after_block", {31'd0, busy32}, 32'd0);

      // Reads outside READY are ignored and data_out stays 0
      step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("idle_rd_dout8", {24'd0, dout}, 32'd0);
      chk("idle_rd_ready8", {31'd0, blk_ready}, 32'd0);

      // 8-bit bus: RFC vector
      write_key8(key_v);
      write_nnc8(nnc_v);
      write_ctr8(32'h0000_0001);
      idle8();
      chk("busy8_start", {31'd0, busy}, 32'd1);
      wait_ready8("lat8_rfc");
      read8(rfc_blk, 64, 1'b0);
      idle8();
      chk("ready8_after_rfc", {31'd0, blk_ready}, 32'd0);
      chk("busy8_after_rfc", {31'd0, busy}, 32'd0);
      chk("dout8_after_rfc", {24'd0, dout}, 32'd0);

      // Counter wrap with auto-increment; key and nonce persist
      write_ctr8(32'hFFFF_FFFF);
      idle8();
      wait_ready8("lat8_ctr_ff");
      read8(blk_ff, 64, 1'b1);
      idle8();
      chk("ready8_autoinc", {31'd0, blk_ready}, 32'd0);
      chk("busy8_autoinc", {31'd0, busy}, 32'd1);
      wait_ready8("lat8_ctr_wrap");
      read8(blk_00, 64, 1'b0);
      idle8();
      chk("busy8_after_wrap", {31'd0, busy}, 32'd0);

      // Key write mid-computation aborts (byte value equals stored key byte 0)
      write_ctr8(32'h0000_0001);
      idle8();
      chk("busy8_abort_start", {31'd0, busy}, 32'd1);
      repeat (38) idle8();
      step8(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      idle8();
      chk("busy8_abort", {31'd0, busy}, 32'd0);
      chk("ready8_abort", {31'd0, blk_ready}, 32'd0);
      repeat (100) idle8();
      chk("ready8_abort_hold", {31'd0, blk_ready}, 32'd0);
      chk("busy8_abort_hold", {31'd0, busy}, 32'd0);

      // Counter write beats a final-beat read with auto_inc set
      write_ctr8(32'h0000_0001);
      idle8();
      wait_ready8("lat8_prio");
      read8(rfc_blk, 63, 1'b1);
      step8(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01);
      step8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      chk("ready8_prio", {31'd0, blk_ready}, 32'd0);
      chk("busy8_prio", {31'd0, busy}, 32'd0);
      step8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      step8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      idle8();
      chk("busy8_prio_restart", {31'd0, busy}, 32'd1);
      wait_ready8("lat8_prio_restart");

      // Reset during READY after 10 beats read
      read8(rfc_blk, 10, 1'b0);
      idle8();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_dout8", {24'd0, dout}, 32'd0);
      chk("midrst_ready8", {31'd0, blk_ready}, 32'd0);
      chk("midrst_busy8", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      write_key8(key_v);
      write_nnc8(nnc_v);
      write_ctr8(32'h0000_0001);
      idle8();
      wait_ready8("lat8_reload");
      read8(rfc_blk, 64, 1'b0);
      idle8();
      chk("ready8_final", {31'd0, blk_ready}, 32'd0);

      repeat (2) @(posedge clk);
      chk("exp8_drained", exp8_q.size(), 32'd0);
      chk("exp32_drained", exp32_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
